sat_expand: RTL and testbench
=============================

// Module: sat_expand
// PURPOSE
//  Inverse of the output saturator: widens osz-bit signed samples to isz bits
//  with a power-of-two gain (arithmetic left shift), preserving headroom so
//  downstream sat stages never clip. An auto-gain FSM backs the shift off on
//  near-full-scale samples and raises it after a quiet window. Sits at ADC/codec
//  ingress, ahead of the wide DSP datapath.
// PARAMETERS
//  isz   17    output data width (signed)
//  osz   12    input data width (signed); SMAX = isz-osz is the max shift
//  WIN   1024  samples per quiet/hold window (power of 2)
//  SHW   3     shift control width; must hold SMAX
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high
//  ena        in   1      input sample strobe, one-cycle pulse, any spacing >=1
//  in         in   osz    signed input sample, valid when ena=1
//  auto       in   1      1=auto gain, 0=manual gain from man_shift
//  man_shift  in   SHW    manual shift; values > SMAX clamp to SMAX
//  out        out  isz    signed widened sample
//  valid      out  1      one-cycle pulse, out valid
//  shift      out  SHW    shift currently in effect for new samples
//  clip_cnt   out  16     count of hot events, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: out=0, valid=0, shift=0, clip_cnt=0, FSM=TRACK, window count=0, peak=0.
//  Datapath, latency 2: cycle after ena, stage1 holds sign-extended in plus the
//   shift sampled with it; next cycle out = ext <<< shift_s1, valid=1. out holds
//   between valids. No overflow possible: shift <= SMAX.
//  Magnitude: mag = |ext <<< shift_s1|; -2^(osz-1) treated as 2^(osz-1)
//   (computed at isz+1 bits, no wrap).
//  Hot: mag >= 2^(isz-2). Cold window: all mag in window < 2^(isz-3).
//  FSM (auto=1), evaluated on the stage-2 sample:
//   TRACK: hot -> shift-=1 (floor 0), clip_cnt+=1, win=0, ->HOLD.
//          else win+=1; at WIN samples: if cold and shift<SMAX then shift+=1;
//          win=0, peak=0, stay TRACK.
//   HOLD:  hot -> shift-=1 (floor 0), clip_cnt+=1, win restarts at 0.
//          else win+=1; at WIN samples -> TRACK, win=0, peak=0 (no increment).
//  Hot and window end on the same sample: hot wins, no increment.
//  New shift applies to the next ena after the update; samples already in
//   stage1 keep their latched shift (back-to-back ena: 1-sample lag allowed).
//  auto=0: shift = min(man_shift, SMAX) every cycle; FSM forced to TRACK,
//   win and peak cleared; clip_cnt still counts hot samples.
//  auto 0->1: starts in TRACK from the current manual shift.
//  reset mid-sample: pipeline flushed; no valid emitted for a sample in flight.
// STRUCTURE
//  sat_defs.vh: state encodings (ST_TRACK, ST_HOLD), SMAX, hot/cold thresholds
//   as localparams derived from isz/osz.
//  Sub-module peak_win: window counter + running max magnitude with clear/
//   restart and cold/end flags; FSM and shift register stay in sat_expand.
// TESTING (isz=17, osz=12, WIN=16 for sim)
//  auto=0, man_shift=5, in=100 -> out=3200 two cycles after ena, one valid pulse.
//  auto=0, man_shift=7 -> shift=5; in=-2048 -> out=-65536, clip_cnt=1.
//  auto=1 shift=5, in=2047 -> out=65504, then shift=4, FSM=HOLD, clip_cnt+1.
//  auto=1, in=10 for 16 samples -> TRACK window ends cold, shift 0->1; repeat to 5.
//  In HOLD, 16 quiet samples -> TRACK with no shift increment; hot on 16th
//   sample of TRACK window -> decrement only.
//  Assert reset between ena and valid -> out=0, valid never pulses, shift=0.

Source files
------------

// File: rtl/sat_expand_pkg.sv
// ============================================================================
//  sat_expand_pkg : shared state encodings and threshold margins
//  Rev 1.0
// ============================================================================
`default_nettype none

package sat_expand_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_TRACK = 1'b0;
    localparam state_t ST_HOLD  = 1'b1;

    // Thresholds sit this many bits below the output full-scale bit.
    localparam int HOT_MARGIN  = 2;
    localparam int COLD_MARGIN = 3;

endpackage : sat_expand_pkg

`default_nettype wire

// File: rtl/sat_expand_peak_win.sv
// ============================================================================
//  sat_expand_peak_win : sample window counter with running peak magnitude
//  Rev 1.0
// ============================================================================
`default_nettype none

module sat_expand_peak_win
    import sat_expand_pkg::*;
#(
    parameter int isz = 17,
    parameter int WIN = 1024
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           force_clr,
    input  logic           smp,
    input  logic           hot,
    input  logic [isz:0]   mag,
    output logic           win_end,
    output logic           cold
);

    localparam int             CW      = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [CW-1:0]  WIN_LAST = CW'(WIN - 1);
    localparam logic [CW-1:0]  CNT_ONE = 1;
    localparam logic [isz:0]   MAG_ONE = 1;
    localparam logic [isz:0]   COLD_TH = MAG_ONE << (isz - COLD_MARGIN);

    logic [CW-1:0] win_q, win_d;
    logic [isz:0]  peak_q, peak_d;
    logic [isz:0]  w_peak_max;

    // The current sample is folded into the peak so the window-end decision
    // covers every sample of the window, including the last one.
    assign w_peak_max = (mag > peak_q) ? mag : peak_q;
    assign win_end    = (win_q == WIN_LAST);
    assign cold       = (w_peak_max < COLD_TH);

    always_comb begin
        win_d  = win_q;
        peak_d = peak_q;
        if (force_clr) begin
            win_d  = '0;
            peak_d = '0;
        end else if (smp) begin
            if (hot || win_end) begin
                win_d  = '0;
                peak_d = '0;
            end else begin
                win_d  = win_q + CNT_ONE;
                peak_d = w_peak_max;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q  <= '0;
            peak_q <= '0;
        end else begin
            win_q  <= win_d;
            peak_q <= peak_d;
        end
    end

endmodule : sat_expand_peak_win

`default_nettype wire

// File: rtl/sat_expand.sv
// ============================================================================
//  sat_expand : widens signed samples with a power-of-two gain and auto-gain
//  Rev 1.0
// ============================================================================
`default_nettype none

module sat_expand
    import sat_expand_pkg::*;
#(
    parameter int isz = 17,
    parameter int osz = 12,
    parameter int WIN = 1024,
    parameter int SHW = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic signed [osz-1:0] in,
    input  logic                  auto,
    input  logic [SHW-1:0]        man_shift,
    output logic signed [isz-1:0] out,
    output logic                  valid,
    output logic [SHW-1:0]        shift,
    output logic [15:0]           clip_cnt
);

    localparam logic [SHW-1:0] SMAX    = SHW'(isz - osz);
    localparam logic [SHW-1:0] SH_ONE  = 1;
    localparam logic [isz:0]   MAG_ONE = 1;
    localparam logic [isz:0]   HOT_TH  = MAG_ONE << (isz - HOT_MARGIN);

    // Stage 1: sign-extended sample plus the shift it was captured with
    logic                  v1_q;
    logic signed [isz-1:0] ext_q;
    logic [SHW-1:0]        sh1_q;

    // Stage 2 / control state
    logic signed [isz-1:0] out_q;
    logic                  valid_q;
    state_t                state_q, state_d;
    logic [SHW-1:0]        shift_q, shift_d;
    logic [15:0]           clip_q,  clip_d;

    logic signed [isz-1:0] w_wide;
    logic [isz:0]          w_wide_x;
    logic [isz:0]          w_mag;
    logic                  w_hot;
    logic                  w_win_end;
    logic                  w_cold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q  <= 1'b0;
            ext_q <= '0;
            sh1_q <= '0;
        end else begin
            v1_q <= ena;
            if (ena) begin
                ext_q <= {{(isz - osz){in[osz-1]}}, in};
                sh1_q <= shift_q;
            end
        end
    end

    // Shift never exceeds isz-osz, so the widened value cannot overflow.
    assign w_wide   = ext_q <<< sh1_q;
    assign w_wide_x = {w_wide[isz-1], w_wide};
    assign w_mag    = w_wide[isz-1] ? -w_wide_x : w_wide_x;
    assign w_hot    = v1_q && (w_mag >= HOT_TH);

    sat_expand_peak_win #(
        .isz (isz),
        .WIN (WIN)
    ) u_peak_win (
        .clk       (clk),
        .reset     (reset),
        .force_clr (~auto),
        .smp       (v1_q),
        .hot       (w_hot),
        .mag       (w_mag),
        .win_end   (w_win_end),
        .cold      (w_cold)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        clip_d  = clip_q;
        if (!auto) begin
            state_d = ST_TRACK;
            shift_d = (man_shift > SMAX) ? SMAX : man_shift;
        end else if (v1_q) begin
            // A hot sample takes priority over a coincident window end.
            if (w_hot) begin
                shift_d = (shift_q != '0) ? (shift_q - SH_ONE) : '0;
                state_d = ST_HOLD;
            end else if (w_win_end) begin
                if ((state_q == ST_TRACK) && w_cold && (shift_q < SMAX))
                    shift_d = shift_q + SH_ONE;
                state_d = ST_TRACK;
            end
        end
        if (w_hot && (clip_q != 16'hFFFF))
            clip_d = clip_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            state_q <= ST_TRACK;
            shift_q <= '0;
            clip_q  <= '0;
        end else begin
            valid_q <= v1_q;
            if (v1_q)
                out_q <= w_wide;
            state_q <= state_d;
            shift_q <= shift_d;
            clip_q  <= clip_d;
        end
    end

    assign out      = out_q;
    assign valid    = valid_q;
    assign shift    = shift_q;
    assign clip_cnt = clip_q;

endmodule : sat_expand

`default_nettype wire

// File: tb/tb_sat_expand.sv
// ============================================================================
//  tb_sat_expand : directed self-checking bench for sat_expand
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_sat_expand;

    localparam int ISZ = 17;
    localparam int OSZ = 12;
    localparam int WIN = 16;
    localparam int SHW = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ena;
    logic signed [OSZ-1:0] in_s;
    logic                  auto_s;
    logic [SHW-1:0]        man_shift;
    logic signed [ISZ-1:0] out_s;
    logic                  valid_s;
    logic [SHW-1:0]        shift_s;
    logic [15:0]           clip_s;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_sh   = 0;

    always #5 clk = ~clk;

    sat_expand #(
        .isz (ISZ),
        .osz (OSZ),
        .WIN (WIN),
        .SHW (SHW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .in        (in_s),
        .auto      (auto_s),
        .man_shift (man_shift),
        .out       (out_s),
        .valid     (valid_s),
        .shift     (shift_s),
        .clip_cnt  (clip_s)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated sample: valid must be low one cycle after ena, high the next.
    task automatic send(input int x, input int exp_out, input string tag);
        in_s = OSZ'(x);
        ena  = 1'b1;
        tick();
        ena  = 1'b0;
        check({tag, " latency"}, valid_s, 0);
        tick();
        check({tag, " valid"}, valid_s, 1);
        check({tag, " out"}, $signed(out_s), exp_out);
    endtask

    task automatic window(input int n, input int x, input string tag);
        for (int i = 0; i < n; i++)
            send(x, x * (1 << exp_sh), tag);
    endtask

    initial begin
        reset     = 1'b1;
        ena       = 1'b0;
        auto_s    = 1'b0;
        man_shift = '0;
        in_s      = '0;
        repeat (2) tick();
        check("reset out", $signed(out_s), 0);
        check("reset valid", valid_s, 0);
        check("reset shift", shift_s, 0);
        check("reset clip", clip_s, 0);
        reset = 1'b0;
        tick();

        // Manual gain
        man_shift = 3'd5;
        repeat (2) tick();
        check("manual shift", shift_s, 5);
        send(100, 3200, "man5");
        tick();
        check("man5 single pulse", valid_s, 0);
        check("man5 hold", $signed(out_s), 3200);

        man_shift = 3'd7;
        repeat (2) tick();
        check("manual clamp", shift_s, 5);
        send(-2048, -65536, "neg fullscale");
        check("manual clip", clip_s, 1);
        check("manual shift kept", shift_s, 5);

        // Auto gain: hot sample backs off and enters HOLD
        auto_s = 1'b1;
        send(2047, 65504, "auto hot");
        check("auto hot shift", shift_s, 4);
        check("auto hot clip", clip_s, 2);
        exp_sh = 4;

        window(WIN, 10, "hold quiet");
        check("hold exit no inc", shift_s, 4);
        window(WIN, 10, "track cold");
        check("track cold inc", shift_s, 5);
        exp_sh = 5;

        // Hot on the last sample of a TRACK window: decrement only
        window(WIN - 1, 10, "pre hot");
        send(2047, 65504, "hot at end");
        check("hot at end shift", shift_s, 4);
        check("hot at end clip", clip_s, 3);
        exp_sh = 4;

        window(WIN, 10, "hold quiet2");
        check("hold exit2", shift_s, 4);
        window(WIN - 1, 10, "warm win");
        send(1500, 24000, "warm sample");
        check("warm no inc", shift_s, 4);
        window(WIN, 10, "track cold2");
        check("track cold inc2", shift_s, 5);

        // Ramp from zero through every shift step up to the cap
        auto_s    = 1'b0;
        man_shift = 3'd0;
        repeat (2) tick();
        check("manual zero", shift_s, 0);
        auto_s = 1'b1;
        exp_sh = 0;
        for (int k = 1; k <= 5; k++) begin
            window(WIN, 10, "ramp");
            exp_sh = k;
            check($sformatf("ramp step %0d", k), shift_s, k);
        end
        window(WIN, 10, "ramp cap");
        check("ramp cap", shift_s, 5);
        check("ramp clip", clip_s, 3);

        // Reset while a sample sits in stage 1
        in_s = 12'sd2047;
        ena  = 1'b1;
        tick();
        ena   = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset out", $signed(out_s), 0);
        check("midreset valid", valid_s, 0);
        check("midreset shift", shift_s, 0);
        check("midreset clip", clip_s, 0);
        tick();
        check("midreset valid held", valid_s, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("postreset valid %0d", i), valid_s, 0);
        end
        check("postreset out", $signed(out_s), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sat_expand

`default_nettype wire
